// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game sequencer.
// Direction encoding: UP=0, RIGHT=1, DOWN=2, LEFT=3; the reverse of a
// direction differs only in bit 1.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_APPLE = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    // Direction that would make the snake turn back onto itself.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game-step tick counter: counts 0..period-1 while enabled, holds its
// value while disabled, and is forced to zero by clear. wrap marks the
// enabled cycle on which the count sits at period-1.
module snake_tick_gen
    import snake_pkg::*;
#(
    parameter int CNT_W = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    output logic             wrap
);

    logic [CNT_W-1:0] count_r;
    logic             at_end_s;

    assign at_end_s = (count_r == (period - {{(CNT_W-1){1'b0}}, 1'b1}));
    assign wrap     = enable && at_end_s;

    // Step counter: clear wins, wrap returns to zero, otherwise count or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (wrap) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/snake_sequencer.sv
// Snake game sequencer: paces game steps, filters direction requests,
// handshakes with the datapath for moves and apple placement, and keeps
// score. Optional macro SNAKE_SPEEDUP_EN shortens the step period by
// TICK_DIV/16 per apple, never below TICK_DIV/4; without it the period is
// fixed at TICK_DIV. reset_n asserts asynchronously and releases
// synchronously to clk.
module snake_sequencer
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 6_250_000,
    parameter int SCORE_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               pause,
    input  logic               dir_req_valid,
    input  logic [1:0]         dir_req,
    input  logic               step_done,
    input  logic               good_collision,
    input  logic               hit_fail,
    input  logic               apple_ack,
    output logic               step_req,
    output logic [1:0]         direction,
    output logic               apple_req,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         state,
    output logic               game_over
);

    localparam int CNT_W = $clog2(TICK_DIV + 1);

    logic [1:0]         rst_sync_r;
    logic               rst_n_s;
    state_t             state_r;
    state_t             state_nxt_s;
    dir_t               dir_r;
    dir_t               pend_r;
    logic [SCORE_W-1:0] score_r;
    logic               step_req_r;
    logic               apple_req_r;
    logic               game_over_r;
    logic [CNT_W-1:0]   period_s;
    logic               wrap_s;
    logic               tick_clear_s;
    logic               tick_en_s;
    logic               start_game_s;
    logic               launch_step_s;
    logic               score_inc_s;
    logic               score_sat_s;
    logic               dir_accept_s;

    // Reset bridge: asserts immediately, releases two clk edges later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    assign start_game_s  = (state_r == ST_IDLE) && start;
    assign launch_step_s = (state_r == ST_RUN) && (state_nxt_s == ST_STEP);
    assign score_sat_s   = &score_r;
    assign score_inc_s   = (state_r == ST_STEP) && start && step_done &&
                           !hit_fail && good_collision;
    assign dir_accept_s  = dir_req_valid && (dir_t'(dir_req) != opposite(dir_r));

    // The counter idles at zero so every game begins with a full interval;
    // pause (or a dropping start) freezes it mid-count.
    assign tick_clear_s = (state_r == ST_IDLE);
    assign tick_en_s    = (state_r == ST_RUN) && start && !pause;

`ifdef SNAKE_SPEEDUP_EN
    localparam logic [CNT_W-1:0] PERIOD_MAX = CNT_W'(TICK_DIV);
    localparam logic [CNT_W-1:0] PERIOD_DEC = CNT_W'(TICK_DIV / 16);
    localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(TICK_DIV / 4);

    logic [CNT_W-1:0] period_r;

    // Step period shrinks with every counted apple down to the floor.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            period_r <= PERIOD_MAX;
        end else if (start_game_s) begin
            period_r <= PERIOD_MAX;
        end else if (score_inc_s && !score_sat_s) begin
            if (period_r >= (PERIOD_MIN + PERIOD_DEC)) begin
                period_r <= period_r - PERIOD_DEC;
            end else begin
                period_r <= PERIOD_MIN;
            end
        end
    end

    assign period_s = period_r;
`else
    assign period_s = CNT_W'(TICK_DIV);
`endif

    snake_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n_s),
        .clear  (tick_clear_s),
        .enable (tick_en_s),
        .period (period_s),
        .wrap   (wrap_s)
    );

    // Next-state decode; a low start aborts any game in progress.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!start)      state_nxt_s = ST_IDLE;
                else if (pause)  state_nxt_s = ST_PAUSE;
                else if (wrap_s) state_nxt_s = ST_STEP;
                else             state_nxt_s = ST_RUN;
            end
            ST_STEP: begin
                if (!start)              state_nxt_s = ST_IDLE;
                else if (!step_done)     state_nxt_s = ST_STEP;
                else if (hit_fail)       state_nxt_s = ST_OVER;
                else if (good_collision) state_nxt_s = ST_APPLE;
                else                     state_nxt_s = ST_RUN;
            end
            ST_APPLE: begin
                if (!start)         state_nxt_s = ST_IDLE;
                else if (apple_ack) state_nxt_s = ST_RUN;
                else                state_nxt_s = ST_APPLE;
            end
            ST_PAUSE: begin
                if (!start)     state_nxt_s = ST_IDLE;
                else if (pause) state_nxt_s = ST_PAUSE;
                else            state_nxt_s = ST_RUN;
            end
            ST_OVER: begin
                if (!start) state_nxt_s = ST_IDLE;
                else        state_nxt_s = ST_OVER;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus state-decoded handshake outputs, all registered.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r     <= ST_IDLE;
            step_req_r  <= 1'b0;
            apple_req_r <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            step_req_r  <= (state_nxt_s == ST_STEP);
            apple_req_r <= (state_nxt_s == ST_APPLE);
            game_over_r <= (state_nxt_s == ST_OVER);
        end
    end

    // Direction: requests collect in pend_r (last wins, reversals dropped)
    // and only move to dir_r as a step launches, so it is stable in STEP.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            dir_r  <= DIR_RIGHT;
            pend_r <= DIR_RIGHT;
        end else if (start_game_s) begin
            dir_r  <= DIR_RIGHT;
            pend_r <= DIR_RIGHT;
        end else begin
            if (dir_accept_s) begin
                pend_r <= dir_t'(dir_req);
            end
            if (launch_step_s) begin
                dir_r <= pend_r;
            end
        end
    end

    // Score: cleared at game start, saturating increment per apple eaten.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            score_r <= {SCORE_W{1'b0}};
        end else if (start_game_s) begin
            score_r <= {SCORE_W{1'b0}};
        end else if (score_inc_s && !score_sat_s) begin
            score_r <= score_r + {{(SCORE_W-1){1'b0}}, 1'b1};
        end
    end

    assign step_req  = step_req_r;
    assign apple_req = apple_req_r;
    assign game_over = game_over_r;
    assign direction = dir_r;
    assign score     = score_r;
    assign state     = state_r;

endmodule

// File: tb/tb_snake_sequencer.sv
// Directed self-checking bench for snake_sequencer with TICK_DIV=16.
module tb_snake_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       pause;
    logic       dir_req_valid;
    logic [1:0] dir_req;
    logic       step_done;
    logic       good_collision;
    logic       hit_fail;
    logic       apple_ack;
    logic       step_req;
    logic [1:0] direction;
    logic       apple_req;
    logic [7:0] score;
    logic [2:0] state;
    logic       game_over;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SNAKE_SPEEDUP_EN
    localparam int APPLE_INTERVAL = 15;
`else
    localparam int APPLE_INTERVAL = 16;
`endif
    localparam int WAIT_LIMIT = 64;

    snake_sequencer #(
        .TICK_DIV (16),
        .SCORE_W  (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .pause          (pause),
        .dir_req_valid  (dir_req_valid),
        .dir_req        (dir_req),
        .step_done      (step_done),
        .good_collision (good_collision),
        .hit_fail       (hit_fail),
        .apple_ack      (apple_ack),
        .step_req       (step_req),
        .direction      (direction),
        .apple_req      (apple_req),
        .score          (score),
        .state          (state),
        .game_over      (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts negedges until step_req is seen high, bounded by WAIT_LIMIT.
    task automatic wait_step(output int k);
        k = 0;
        while (step_req !== 1'b1 && k < WAIT_LIMIT) begin
            @(negedge clk);
            k++;
        end
    endtask

    // One-cycle step_done pulse with the given collision flags.
    task automatic finish_step(input logic good, input logic fail);
        step_done = 1'b1; good_collision = good; hit_fail = fail;
        @(negedge clk);
        step_done = 1'b0; good_collision = 1'b0; hit_fail = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; pause = 1'b0; dir_req_valid = 1'b0;
        dir_req = 2'd0; step_done = 1'b0; good_collision = 1'b0;
        hit_fail = 1'b0; apple_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if ({step_req, apple_req, game_over} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {step_req, apple_req, game_over}); end
        n_cmp++; if (score !== 8'd0) begin n_err++; $display("FAIL reset_score: got %0d want 0", score); end
        n_cmp++; if (direction !== 2'd1) begin n_err++; $display("FAIL reset_dir: got %0d want 1", direction); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL idle_hold: got %0d want 0", state); end
    endtask

    task automatic test_start_step;
        int k;
        start = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL start_run: got %0d want 1", state); end
        wait_step(k);
        n_cmp++; if (k !== 16) begin n_err++; $display("FAIL first_interval: got %0d want 16", k); end
        n_cmp++; if (state !== 3'd2 || direction !== 2'd1) begin n_err++; $display("FAIL step_entry: state %0d dir %0d want 2/1", state, direction); end
        @(negedge clk);
        n_cmp++; if (step_req !== 1'b1) begin n_err++; $display("FAIL step_level: got %b want 1", step_req); end
        finish_step(1'b0, 1'b0);
        n_cmp++; if (state !== 3'd1 || step_req !== 1'b0 || score !== 8'd0) begin n_err++; $display("FAIL plain_step: state %0d req %b score %0d want 1/0/0", state, step_req, score); end
    endtask

    task automatic test_direction;
        int k;
        dir_req_valid = 1'b1; dir_req = 2'd3;
        @(negedge clk);
        dir_req = 2'd0;
        @(negedge clk);
        dir_req_valid = 1'b0;
        wait_step(k);
        n_cmp++; if (k >= WAIT_LIMIT || direction !== 2'd0) begin n_err++; $display("FAIL dir_last_wins: dir %0d wait %0d want 0", direction, k); end
        finish_step(1'b0, 1'b0);
        dir_req_valid = 1'b1; dir_req = 2'd2;
        @(negedge clk);
        dir_req_valid = 1'b0;
        wait_step(k);
        n_cmp++; if (k >= WAIT_LIMIT || direction !== 2'd0) begin n_err++; $display("FAIL dir_reversal_dropped: dir %0d wait %0d want 0", direction, k); end
        dir_req_valid = 1'b1; dir_req = 2'd1;
        @(negedge clk);
        dir_req_valid = 1'b0;
        n_cmp++; if (step_req !== 1'b1 || direction !== 2'd0) begin n_err++; $display("FAIL dir_stable_in_step: req %b dir %0d want 1/0", step_req, direction); end
        finish_step(1'b0, 1'b0);
        wait_step(k);
        n_cmp++; if (k >= WAIT_LIMIT || direction !== 2'd1) begin n_err++; $display("FAIL dir_turn_right: dir %0d wait %0d want 1", direction, k); end
        finish_step(1'b0, 1'b0);
        dir_req_valid = 1'b1; dir_req = 2'd3;
        @(negedge clk);
        dir_req_valid = 1'b0;
        wait_step(k);
        n_cmp++; if (k >= WAIT_LIMIT || direction !== 2'd1) begin n_err++; $display("FAIL dir_lone_left: dir %0d wait %0d want 1", direction, k); end
        finish_step(1'b0, 1'b0);
    endtask

    task automatic test_ignored;
        step_done = 1'b1; good_collision = 1'b1; apple_ack = 1'b1;
        @(negedge clk);
        step_done = 1'b0; good_collision = 1'b0; apple_ack = 1'b0;
        n_cmp++; if (state !== 3'd1 || score !== 8'd0 || apple_req !== 1'b0) begin n_err++; $display("FAIL ignore_outside: state %0d score %0d areq %b want 1/0/0", state, score, apple_req); end
    endtask

    task automatic test_apple;
        int k;
        wait_step(k);
        finish_step(1'b1, 1'b0);
        n_cmp++; if (state !== 3'd3 || apple_req !== 1'b1 || score !== 8'd1) begin n_err++; $display("FAIL apple_entry: state %0d areq %b score %0d want 3/1/1", state, apple_req, score); end
        repeat (3) @(negedge clk);
        n_cmp++; if (apple_req !== 1'b1) begin n_err++; $display("FAIL apple_hold: got %b want 1", apple_req); end
        apple_ack = 1'b1;
        @(negedge clk);
        apple_ack = 1'b0;
        n_cmp++; if (state !== 3'd1 || apple_req !== 1'b0) begin n_err++; $display("FAIL apple_ack: state %0d areq %b want 1/0", state, apple_req); end
        wait_step(k);
        n_cmp++; if (k !== APPLE_INTERVAL) begin n_err++; $display("FAIL apple_interval: got %0d want %0d", k, APPLE_INTERVAL); end
        finish_step(1'b0, 1'b0);
    endtask

    task automatic test_over;
        int k;
        wait_step(k);
        finish_step(1'b1, 1'b1);
        n_cmp++; if (state !== 3'd5 || game_over !== 1'b1 || score !== 8'd1) begin n_err++; $display("FAIL over_entry: state %0d go %b score %0d want 5/1/1", state, game_over, score); end
        apple_ack = 1'b1; step_done = 1'b1;
        repeat (4) @(negedge clk);
        apple_ack = 1'b0; step_done = 1'b0;
        n_cmp++; if (state !== 3'd5 || game_over !== 1'b1) begin n_err++; $display("FAIL over_hold: state %0d go %b want 5/1", state, game_over); end
        start = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== 3'd0 || game_over !== 1'b0 || score !== 8'd1) begin n_err++; $display("FAIL over_exit: state %0d go %b score %0d want 0/0/1", state, game_over, score); end
    endtask

    task automatic test_pause;
        int k;
        start = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== 3'd1 || score !== 8'd0) begin n_err++; $display("FAIL restart: state %0d score %0d want 1/0", state, score); end
        repeat (7) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL pause_entry: got %0d want 4", state); end
        repeat (19) @(negedge clk);
        pause = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL pause_exit: got %0d want 1", state); end
        wait_step(k);
        n_cmp++; if (k !== 9) begin n_err++; $display("FAIL pause_resume_interval: got %0d want 9", k); end
        pause = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL pause_deferred_step: got %0d want 2", state); end
        finish_step(1'b0, 1'b0);
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL pause_after_done: got %0d want 1", state); end
        @(negedge clk);
        n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL pause_taken: got %0d want 4", state); end
        pause = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_step_reset;
        int k;
        wait_step(k);
        finish_step(1'b1, 1'b0);
        apple_ack = 1'b1;
        @(negedge clk);
        apple_ack = 1'b0;
        dir_req_valid = 1'b1; dir_req = 2'd0;
        @(negedge clk);
        dir_req_valid = 1'b0;
        wait_step(k);
        n_cmp++; if (k >= WAIT_LIMIT || score !== 8'd1 || direction !== 2'd0) begin n_err++; $display("FAIL pre_reset: wait %0d score %0d dir %0d want 1/0", k, score, direction); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (step_req !== 1'b0 || state !== 3'd0 || score !== 8'd0) begin n_err++; $display("FAIL async_reset: req %b state %0d score %0d want 0/0/0", step_req, state, score); end
        n_cmp++; if (direction !== 2'd1) begin n_err++; $display("FAIL async_reset_dir: got %0d want 1", direction); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (state !== 3'd1 || step_req !== 1'b0) begin n_err++; $display("FAIL reset_release: state %0d req %b want 1/0", state, step_req); end
    endtask

    task automatic test_saturation;
        int k;
        int timeouts;
        timeouts = 0;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            wait_step(k);
            if (k >= WAIT_LIMIT) timeouts++;
            finish_step(1'b1, 1'b0);
            if (i < 255) begin
                apple_ack = 1'b1;
                @(negedge clk);
                apple_ack = 1'b0;
            end
        end
        n_cmp++; if (timeouts !== 0) begin n_err++; $display("FAIL sat_timeouts: got %0d want 0", timeouts); end
        n_cmp++; if (score !== 8'hFF || state !== 3'd3) begin n_err++; $display("FAIL score_saturate: score %0d state %0d want 255/3", score, state); end
        start = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== 3'd0 || apple_req !== 1'b0 || score !== 8'hFF) begin n_err++; $display("FAIL abort_apple: state %0d areq %b score %0d want 0/0/255", state, apple_req, score); end
    endtask

    initial begin
        test_reset();
        test_start_step();
        test_direction();
        test_ignored();
        test_apple();
        test_over();
        test_pause();
        test_mid_step_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snake_sequencer.md
SNAKE_SEQUENCER -- requirements
Module: snake_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 6_250_000, clk cycles per game step (minimum 4).
REQ-002 SHALL have parameter SCORE_W, default 8, score counter width.
REQ-003 SHALL have port clk, input, 1, single clock for all state (50 MHz board clock).
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, level game-enable switch.
REQ-006 SHALL have port pause, input, 1, level pause request.
REQ-007 SHALL have port dir_req_valid, input, 1, one-cycle direction request strobe.
REQ-008 SHALL have port dir_req, input, 2, requested direction.
REQ-009 SHALL have port step_done, input, 1, datapath has finished the step.
REQ-010 SHALL have port good_collision, input, 1, head hit apple; sampled with step_done.
REQ-011 SHALL have port hit_fail, input, 1, wall/self hit; sampled with step_done.
REQ-012 SHALL have port apple_ack, input, 1, new apple placed.
REQ-013 SHALL have port step_req, output, 1, advance snake one cell.
REQ-014 SHALL have port direction, output, 2, direction applied to the current step.
REQ-015 SHALL have port apple_req, output, 1, request new apple coordinates.
REQ-016 SHALL have port score, output, SCORE_W, apples eaten.
REQ-017 SHALL have port state, output, 3, current FSM state.
REQ-018 SHALL have port game_over, output, 1, high while in OVER.

Function
REQ-019 SHALL use direction encoding UP=0, RIGHT=1, DOWN=2, LEFT=3; opposite(d) = d XOR 2'b10.
REQ-020 SHALL implement states IDLE, RUN, STEP, APPLE, PAUSE, OVER.
REQ-021 IDLE->RUN SHALL occur on the first cycle start is high; on entry, score SHALL clear, direction SHALL be RIGHT and the tick counter SHALL be 0.
REQ-022 In RUN the tick counter SHALL count 0..period-1; at period-1 it SHALL wrap to 0, the FSM SHALL go to STEP and step_req SHALL rise on the next cycle.
REQ-023 step_req SHALL be a level held high throughout STEP; it SHALL drop the cycle after step_done is sampled high.
REQ-024 While step_req is high, direction SHALL be stable.
REQ-025 dir_req_valid SHALL load a pending register unless dir_req == opposite(direction); reversals SHALL be dropped.
REQ-026 Multiple requests within one step SHALL be last-wins.
REQ-027 The pending direction SHALL be copied to direction on the RUN->STEP transition.
REQ-028 On step_done in STEP, hit_fail SHALL take priority and go to OVER.
REQ-029 On step_done in STEP, if hit_fail is low and good_collision is high: score SHALL increment, saturating at all-ones, and the FSM SHALL go to APPLE.
REQ-030 On step_done in STEP with neither hit_fail nor good_collision: the FSM SHALL return to RUN.
REQ-031 apple_req SHALL be high throughout APPLE; apple_ack SHALL return the FSM to RUN.
REQ-032 apple_ack SHALL be ignored outside APPLE.
REQ-033 pause high in RUN SHALL go to PAUSE with the tick counter frozen; pause low SHALL return to RUN and counting resumes from the held value.
REQ-034 pause high in STEP or APPLE SHALL be deferred until RUN.
REQ-035 start low in any state except IDLE SHALL force IDLE next cycle, dropping step_req and apple_req, with score held.
REQ-036 OVER SHALL hold score and game_over; only start low SHALL exit OVER, to IDLE.
REQ-037 step_done outside STEP SHALL be ignored.

Reset
REQ-038 reset_n low SHALL immediately force IDLE, tick counter 0, and pending/direction RIGHT.
REQ-039 reset_n low SHALL immediately force step_req=0, apple_req=0, score=0, game_over=0 and state=IDLE.
REQ-040 Deassertion SHALL be synchronized to clk; reset mid-STEP SHALL abandon the handshake.

Configuration
REQ-041 With SNAKE_SPEEDUP_EN defined, each score increment SHALL reduce period by TICK_DIV/16, floored at TICK_DIV/4, and period SHALL reset to TICK_DIV on IDLE->RUN.
REQ-042 Without SNAKE_SPEEDUP_EN, period SHALL be constant TICK_DIV.

Structure
REQ-043 A shared package snake_pkg SHALL hold dir_t, state_t (IDLE=0, RUN=1, STEP=2, APPLE=3, PAUSE=4, OVER=5) and the opposite() function.
REQ-044 The tick counter with load/freeze/period input SHALL be sub-module snake_tick_gen.

Verification (TICK_DIV=16)
REQ-045 Scenario 1: reset, then start=1 -> state RUN; step_req rises 16 cycles after entering RUN, direction=1; step_done -> RUN, score=0.
REQ-046 Scenario 2: direction=RIGHT, dir_req=LEFT strobe, then dir_req=UP strobe -> next step direction=0; lone LEFT request -> direction unchanged.
REQ-047 Scenario 3: step_done with good_collision=1 -> score=1, apple_req high until apple_ack, then RUN; with SNAKE_SPEEDUP_EN the next step interval is 15 cycles.
REQ-048 Scenario 4: step_done with hit_fail=1 and good_collision=1 -> OVER, game_over=1, score unchanged; start=0 -> IDLE.
REQ-049 Scenario 5: pause at count 7 for 20 cycles -> step_req arrives 9 cycles after release; pause during STEP -> PAUSE only after step_done.
REQ-050 Scenario 6: reset_n low mid-STEP -> step_req=0 the same cycle, score=0, state=IDLE.
